// File: rtl/servo_angle_ctrl.sv
// Angle command to servo pulse-width converter: shift-add multiply, restoring divide by 180,
// then a per-frame bounded slew of duty_cycle toward the computed target.
module servo_angle_ctrl #(
    parameter int unsigned PERIOD_CYCLES = 500000,
    parameter int unsigned MIN_PULSE     = 12500,
    parameter int unsigned MAX_PULSE     = 62500,
    parameter int unsigned SLEW_STEP     = 250
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    input  logic [7:0]  cmd_angle,
    output logic        cmd_ready,
    output logic        cmd_err,
    output logic [31:0] duty_cycle,
    output logic [31:0] period,
    output logic        at_target,
    output logic        frame_tick
);
    localparam logic [31:0] SPAN     = 32'(MAX_PULSE - MIN_PULSE);
    localparam logic [31:0] CENTER   = 32'((MIN_PULSE + MAX_PULSE) / 2);
    localparam logic [31:0] MIN_P    = 32'(MIN_PULSE);
    localparam logic [31:0] STEP     = 32'(SLEW_STEP);
    localparam logic [31:0] LAST_CNT = 32'(PERIOD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, LOAD} state_e;

    state_e      state_q;
    logic [4:0]  step_q;
    logic [7:0]  mplier_q;
    logic [31:0] mcand_q;
    logic [31:0] acc_q;
    logic [7:0]  rem_q;
    logic [31:0] target_q;
    logic [31:0] duty_q;
    logic [31:0] cnt_q;
    logic        ready_q;
    logic        err_q;
    logic        at_target_q;
    logic        tick_q;

    logic [7:0]  angle_clamped;
    logic [8:0]  rem_shift;
    logic        rem_ge;
    logic [7:0]  rem_d;
    logic [31:0] diff;
    logic [31:0] duty_d;

    assign angle_clamped = (cmd_angle > 8'd180) ? 8'd180 : cmd_angle;

    // Restoring divide step: acc_q shifts out dividend bits at the top and collects quotient bits at the bottom.
    always_comb begin
        rem_shift = {rem_q, acc_q[31]};
        rem_ge    = (rem_shift >= 9'd180);
        rem_d     = rem_ge ? 8'(rem_shift - 9'd180) : rem_shift[7:0];
    end

    always_comb begin
        diff   = '0;
        duty_d = duty_q;
        if (duty_q < target_q) begin
            diff   = target_q - duty_q;
            duty_d = ((STEP == '0) || (diff <= STEP)) ? target_q : duty_q + STEP;
        end else if (duty_q > target_q) begin
            diff   = duty_q - target_q;
            duty_d = ((STEP == '0) || (diff <= STEP)) ? target_q : duty_q - STEP;
        end
    end

    // Handshake: a command transfers on a rising edge with cmd_valid && cmd_ready; cmd_ready stays low
    // until the new target is loaded, so the sender must hold cmd_valid/cmd_angle while ready is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            step_q   <= '0;
            mplier_q <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            target_q <= CENTER;
            ready_q  <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid && ready_q) begin
                        mplier_q <= angle_clamped;
                        mcand_q  <= SPAN;
                        acc_q    <= '0;
                        step_q   <= '0;
                        err_q    <= (cmd_angle > 8'd180);
                        ready_q  <= 1'b0;
                        state_q  <= MUL;
                    end
                end
                MUL: begin
                    if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    step_q   <= step_q + 5'd1;
                    if (step_q == 5'd7) begin
                        step_q  <= '0;
                        rem_q   <= '0;
                        state_q <= DIV;
                    end
                end
                DIV: begin
                    acc_q  <= {acc_q[30:0], rem_ge};
                    rem_q  <= rem_d;
                    step_q <= step_q + 5'd1;
                    if (step_q == 5'd31) state_q <= LOAD;
                end
                LOAD: begin
                    target_q <= MIN_P + acc_q;
                    ready_q  <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // duty_q moves only when tick_q is high, and reads the target as it stood before this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            tick_q      <= 1'b0;
            duty_q      <= CENTER;
            at_target_q <= 1'b1;
        end else begin
            if (cnt_q == LAST_CNT) begin
                cnt_q  <= '0;
                tick_q <= 1'b1;
            end else begin
                cnt_q  <= cnt_q + 32'd1;
                tick_q <= 1'b0;
            end
            if (tick_q) duty_q <= duty_d;
            at_target_q <= (duty_q == target_q);
        end
    end

    assign cmd_ready  = ready_q;
    assign cmd_err    = err_q;
    assign duty_cycle = duty_q;
    assign period     = 32'(PERIOD_CYCLES);
    assign at_target  = at_target_q;
    assign frame_tick = tick_q;
endmodule
